// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle control sequencer for the 32-bit RISC datapath with a shared memory port.
// Optional: define OVERFLOW_TRAP_EN to trap signed overflow at register write-back.
module multi_cycle_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    input  logic             Overflow,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    // zero is consumed by the datapath's PC-load gate, not by the sequencer
    logic w_unused;
    assign w_unused = ^{zero, Overflow};

    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_retire    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end else begin
                    w_next  = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    6'h00:        w_next = S_EXEC;
                    6'h23, 6'h2B: w_next = S_MEMADR;
                    6'h04:        w_next = S_BRANCH;
                    6'h02:        w_next = S_JUMP;
                    6'h08:        w_next = S_ADDI_EX;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (Opcode == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_retire = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                w_retire = mem_ready;
                w_next   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = S_RWB;
            end
            S_RWB: begin
                RegDst = 1'b1;
`ifdef OVERFLOW_TRAP_EN
                RegWrite   = !Overflow;
                illegal_op = Overflow;
                w_retire   = !Overflow;
`else
                RegWrite = 1'b1;
                w_retire = 1'b1;
`endif
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                w_retire    = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                w_retire = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
`ifdef OVERFLOW_TRAP_EN
                RegWrite   = !Overflow;
                illegal_op = Overflow;
                w_retire   = !Overflow;
`else
                RegWrite = 1'b1;
                w_retire = 1'b1;
`endif
            end
            S_TRAP: begin
                illegal_op = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset masks every strobe combinationally so a stalled access is dropped in the same cycle
        if (Reset) begin
            w_retire    = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            illegal_op  = 1'b0;
        end
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Scoreboard bench for multi_cycle_control_fsm: per-cycle expected state/strobes/retire count.
module tb_multi_cycle_control_fsm;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       ill;
    } ctrl_t;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic        z;
        logic [3:0]  st;
        ctrl_t       ctrl;
        int unsigned ret;
        logic        chk;
    } item_t;

    logic        clock = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  Opcode = '0;
    logic        zero = 1'b0;
    logic        Overflow = 1'b0;
    logic        mem_ready = 1'b1;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        PCWrite4, PCWriteCond4, IorD4, MemRead4, MemWrite4, IRWrite4;
    logic        MemtoReg4, RegDst4, RegWrite4, ALUSrcA4, illegal_op4;
    logic [1:0]  ALUSrcB4, ALUOp4, PCSource4;
    logic [3:0]  state4;
    logic [3:0]  retired4;

    item_t       q[$];
    int unsigned m_ret;
    logic        cur_z;
    int unsigned n_total = 0;
    int unsigned n_bad = 0;

    always #5 clock = ~clock;

    multi_cycle_control_fsm dut (
        .clock(clock), .Reset(Reset), .Opcode(Opcode), .zero(zero), .Overflow(Overflow),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .illegal_op(illegal_op),
        .retired(retired)
    );

    multi_cycle_control_fsm #(.CNT_W(4)) dut4 (
        .clock(clock), .Reset(Reset), .Opcode(Opcode), .zero(zero), .Overflow(Overflow),
        .mem_ready(mem_ready), .PCWrite(PCWrite4), .PCWriteCond(PCWriteCond4), .IorD(IorD4),
        .MemRead(MemRead4), .MemWrite(MemWrite4), .IRWrite(IRWrite4), .MemtoReg(MemtoReg4),
        .RegDst(RegDst4), .RegWrite(RegWrite4), .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4),
        .ALUOp(ALUOp4), .PCSource(PCSource4), .state(state4), .illegal_op(illegal_op4),
        .retired(retired4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctrl_t ctrl_for(input logic [3:0] st, input logic mr);
        ctrl_t c = '0;
        case (st)
            4'd0:  begin c.mrd = 1; c.srcb = 2'b01; if (mr) begin c.irw = 1; c.pcw = 1; end end
            4'd1:  c.srcb = 2'b11;
            4'd2:  begin c.srca = 1; c.srcb = 2'b10; end
            4'd3:  begin c.mrd = 1; c.iord = 1; end
            4'd4:  begin c.rw = 1; c.m2r = 1; end
            4'd5:  begin c.mwr = 1; c.iord = 1; end
            4'd6:  begin c.srca = 1; c.aluop = 2'b10; end
            4'd7:  begin c.rw = 1; c.rdst = 1; end
            4'd8:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
            4'd9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
            4'd10: begin c.srca = 1; c.srcb = 2'b10; end
            4'd11: c.rw = 1;
            4'd12: c.ill = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic push(input logic rst, input logic [5:0] op, input logic [3:0] st,
                        input logic mr, input logic chk);
        item_t it;
        it.rst  = rst;
        it.op   = op;
        it.mr   = mr;
        it.z    = cur_z;
        it.st   = st;
        it.ctrl = rst ? ctrl_t'('0) : ctrl_for(st, mr);
        it.ret  = m_ret;
        it.chk  = chk;
        q.push_back(it);
    endtask

    // mem_ready is irrelevant outside FETCH/MEMRD/MEMWR, so it is randomised there
    task automatic push_instr(input logic [5:0] op, input int unsigned f_stall,
                              input int unsigned m_stall);
        for (int unsigned i = 0; i < f_stall; i++) push(0, op, 4'd0, 1'b0, 1);
        push(0, op, 4'd0, 1'b1, 1);
        push(0, op, 4'd1, 1'($urandom_range(1)), 1);
        case (op)
            6'h00: begin
                push(0, op, 4'd6, 1'($urandom_range(1)), 1);
                push(0, op, 4'd7, 1'($urandom_range(1)), 1); m_ret++;
            end
            6'h23: begin
                push(0, op, 4'd2, 1'($urandom_range(1)), 1);
                for (int unsigned i = 0; i < m_stall; i++) push(0, op, 4'd3, 1'b0, 1);
                push(0, op, 4'd3, 1'b1, 1);
                push(0, op, 4'd4, 1'($urandom_range(1)), 1); m_ret++;
            end
            6'h2B: begin
                push(0, op, 4'd2, 1'($urandom_range(1)), 1);
                for (int unsigned i = 0; i < m_stall; i++) push(0, op, 4'd5, 1'b0, 1);
                push(0, op, 4'd5, 1'b1, 1); m_ret++;
            end
            6'h04: begin push(0, op, 4'd8, 1'($urandom_range(1)), 1); m_ret++; end
            6'h02: begin push(0, op, 4'd9, 1'($urandom_range(1)), 1); m_ret++; end
            6'h08: begin
                push(0, op, 4'd10, 1'($urandom_range(1)), 1);
                push(0, op, 4'd11, 1'($urandom_range(1)), 1); m_ret++;
            end
            default: push(0, op, 4'd12, 1'($urandom_range(1)), 1);
        endcase
    endtask

    task automatic drain();
        item_t it;
        ctrl_t obs;
        while (q.size() > 0) begin
            it = q.pop_front();
            Reset     = it.rst;
            Opcode    = it.op;
            mem_ready = it.mr;
            zero      = it.z;
            @(negedge clock);
            obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
            check($sformatf("ctrl st%0d", it.st), 32'(obs), 32'(it.ctrl));
            check("rd_wr_exclusive", 32'(MemRead & MemWrite), 32'd0);
            if (it.chk) begin
                check("state", 32'(state), 32'(it.st));
                check("retired", retired, it.ret);
                check("retired4", 32'(retired4), it.ret & 32'hF);
                check("state4", 32'(state4), 32'(it.st));
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        m_ret = 0;
        cur_z = 1'b0;
        // two reset cycles; counter/state settled by the second
        push(1, 6'h00, 4'd0, 1'b1, 0);
        push(1, 6'h00, 4'd0, 1'b1, 1);
        drain();

        push_instr(6'h00, 0, 0); drain();          // R-type
        push_instr(6'h23, 0, 3); drain();          // lw with 3 stall cycles
        cur_z = 1'b1; push_instr(6'h04, 0, 0); drain();
        cur_z = 1'b0; push_instr(6'h04, 0, 0); drain();
        push_instr(6'h3F, 0, 0); drain();          // illegal
        push_instr(6'h2B, 0, 0); drain();          // sw
        push_instr(6'h2B, 0, 2); drain();          // sw with stalls
        push_instr(6'h02, 0, 0); drain();          // j
        push_instr(6'h08, 0, 0); drain();          // addi
        push_instr(6'h00, 2, 0); drain();          // fetch stall
        push_instr(6'h05, 0, 0); drain();          // another illegal

        // sw aborted by Reset in the middle of a MEMWR stall
        push(0, 6'h2B, 4'd0, 1'b1, 1);
        push(0, 6'h2B, 4'd1, 1'b1, 1);
        push(0, 6'h2B, 4'd2, 1'b1, 1);
        push(0, 6'h2B, 4'd5, 1'b0, 1);
        push(0, 6'h2B, 4'd5, 1'b0, 1);
        push(1, 6'h2B, 4'd5, 1'b0, 1);
        drain();
        m_ret = 0;
        push_instr(6'h00, 0, 0); drain();

        // 16 more R-types: 4-bit counter wraps through 15 -> 0
        for (int unsigned i = 0; i < 16; i++) begin
            push_instr(6'h00, 0, 0);
            drain();
        end
        push_instr(6'h23, 1, 0); drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_fsm.md
Name: multi_cycle_control_fsm

Overview:
Multi-cycle sequencer for the 32-bit RISC datapath, replacing the single-cycle control unit when instruction and data share one memory port.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Drives the PC, IR, register-file, ALU-mux and memory enables.
- Stalls on a memory-ready handshake.
- Keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Opcode  input  6  Instruction[31:26] from IR
zero  input  1  ALU zero flag
Overflow  input  1  ALU signed overflow flag
mem_ready  input  1  memory completes current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if zero=1
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  write-back select: 1=MDR, 0=ALUOut
RegDst  output  1  1=rd[15:11], 0=rt[20:16]
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=rs
ALUSrcB  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state code (debug)
illegal_op  output  1  pulse: unsupported opcode decoded
retired  output  CNT_W  instructions completed since reset

Behaviour:
- Clock and reset: single clock domain; Reset is sampled at the rising clock edge.
- Reset effect: while Reset=1, every output enable is forced 0, ALUSrcB/ALUOp/PCSource=00, and illegal_op=0. On the edge, state<=FETCH(0) and retired<=0.
- Output style: Moore decode of the state register, except the mem_ready-qualified strobes noted below.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, TRAP=12. Codes 13-15 are unreachable; if entered, go to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - mem_ready=0: hold in FETCH.
  - mem_ready=1: IRWrite=1 and PCWrite=1 in that same cycle; next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next state by Opcode:
  - 0x00 -> EXEC
  - 0x23 / 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDI_EX
  - anything else -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMRD if Opcode=0x23, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Retires; next FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready=1; retires on the mem_ready cycle; next FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Retires; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Retires; next FETCH.
- JUMP: PCWrite=1, PCSource=10. Retires; next FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Retires; next FETCH.
- TRAP: illegal_op=1 for exactly one cycle; no write enables. Does not retire; next FETCH (instruction skipped; PC already advanced).
- Latency with mem_ready tied 1:
  - R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4, illegal 3.
  - Each mem_ready=0 cycle adds one cycle.
- Retire counter: retired increments by 1 in the final cycle of each legal instruction and wraps all-ones -> 0.
- MemRead and MemWrite are never both 1.
- Reset during a stall: abort the access; the next cycle is FETCH with retired=0 and no partial write-back.

Optional Feature:
OVERFLOW_TRAP_EN
- Defined: in RWB and ADDI_WB, if Overflow=1, RegWrite is suppressed, illegal_op pulses 1 for that cycle, and the instruction does not retire. Next state is still FETCH.
- Undefined: Overflow is ignored; write-back is unconditional.

Test Plan:
- Reset=1 for 2 cycles, mem_ready=1 -> all enables 0 during reset; state=0 and retired=0 after release; first cycle asserts MemRead=1, IRWrite=1, PCWrite=1.
- R-type (Opcode 0x00), mem_ready=1 -> state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; retired 0->1.
- lw (0x23) with mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; MemRead and IorD held for 4 cycles; RegWrite=1 with MemtoReg=1 in state 4.
- beq (0x04) with zero=1, then with zero=0 -> PCWriteCond=1 and PCSource=01 in state 8 in both runs; 3-cycle latency; retired +1 each.
- Opcode 0x3F -> states 0,1,12,0; illegal_op high one cycle; no RegWrite or MemWrite; retired unchanged.
- sw (0x2B) with Reset asserted mid-MEMWR stall -> MemWrite drops with Reset; state=0 and retired=0 on the next cycle. Separately, with CNT_W=4 and 16 R-types -> retired wraps 15->0.
